alpharetz_spi_controller: RTL and testbench
===========================================

Name: alpharetz_spi_controller

Overview:
- Single-controller SPI master (mode 0: CPOL=0, CPHA=0, MSB first) driving up to PERI_CNT peripherals with one active-low select each.
- Accepts a one-word transmit request from the core, runs one full-duplex transfer, and returns the received word.
- Sits between the Alpharetz I/O fabric and the external SPI pins.

Parameters:
- SPI_DATA_WIDTH, 8: bits per transaction (≥2).
- PERI_CNT, 4: number of peripherals / select lines (≥1).
- P_ADDR_WIDTH, 2: width of p_addr; must be ≥ clog2(PERI_CNT).
- CLK_DIV, 4: enabled sys_clk cycles per p_clk half-period (1..65535, 16-bit divider counter).

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- sys_clk_en  in  1  clock enable; state, counters and registered outputs advance only when high.
- start_txn  in  1  request a transaction (level-sampled).
- tx_data  in  SPI_DATA_WIDTH  word to transmit, latched at accept.
- p_addr  in  P_ADDR_WIDTH  target peripheral index, latched at accept.
- cipo  in  1  serial data from peripheral.
- copi  out  1  serial data to peripheral.
- p_clk  out  1  SPI serial clock.
- p_sel_n  out  PERI_CNT  one-hot-low chip selects.
- end_txn  out  1  one-cycle completion pulse.
- rx_data  out  SPI_DATA_WIDTH  last received word.
- busy  out  1  high while a transaction is in progress.

Behaviour:
- Reset (async, sys_rst_n=0):
  - State = IDLE; p_clk=0, copi=0, p_sel_n all 1s.
  - end_txn=0, busy=0, rx_data=0; divider, bit counter and shift registers cleared.
  - A reset mid-transfer aborts immediately, with no end_txn.
- All outputs are registered. With sys_clk_en=0, everything holds its value, including an end_txn pulse, which is consumed on the next enabled cycle.
- FSM states: IDLE, SETUP, TRANSFER, HOLD.
- IDLE:
  - On an enabled cycle with start_txn=1 and p_addr<PERI_CNT: latch tx_data into the TX shift register and latch p_addr.
  - Drive p_sel_n[p_addr]=0 and copi=tx_data[MSB]; set busy=1; go to SETUP.
  - If p_addr≥PERI_CNT, the request is ignored: no select, busy stays 0.
- SETUP: hold for CLK_DIV enabled cycles with p_clk=0, then go to TRANSFER.
- TRANSFER:
  - p_clk toggles every CLK_DIV enabled cycles.
  - Rising edge of p_clk: shift cipo into the RX shift register LSB (MSB received first).
  - Falling edge: drive the next TX bit on copi.
  - After the SPI_DATA_WIDTH-th falling edge (p_clk back at 0), go to HOLD.
- HOLD:
  - Hold select for CLK_DIV enabled cycles.
  - On exit: p_sel_n all 1s, copi=0, rx_data ← RX shift register, end_txn=1 for exactly one enabled cycle, busy=0; return to IDLE.
- Total busy duration: (2·SPI_DATA_WIDTH+2)·CLK_DIV enabled cycles; 72 cycles at defaults.
- start_txn while busy=1 is ignored; it is not queued.
- start_txn in the cycle where end_txn=1 is accepted, giving back-to-back transactions.
- tx_data and p_addr changes after acceptance have no effect.
- rx_data is stable between completions.

Decomposition:
- Shared package alpharetz_spi_pkg holds:
  - SPI_DATA_WIDTH, P_ADDR_WIDTH, PERI_CNT defaults (currently in alpharetz_spi_params.svh).
  - An spi_state_e enum {IDLE, SETUP, TRANSFER, HOLD}.
- One natural sub-module: alpharetz_spi_clk_div. It holds the 16-bit enable-gated counter and generates half-period tick pulses, with a clear input from the FSM.
- Shift registers and the select decoder stay in the top module.

Test Plan:
- Reset: hold sys_rst_n=0 mid-sim → p_sel_n=4'b1111, p_clk=0, busy=0, end_txn=0, rx_data=0, asynchronously, without waiting for a clock edge.
- Loopback: cipo tied to copi, tx_data=8'hA5, p_addr=2 → p_sel_n=4'b1011 during transfer, copi bit sequence 1,0,1,0,0,1,0,1; 8 p_clk pulses, each high for 4 cycles; busy high for 72 cycles; end_txn single pulse; rx_data=8'hA5.
- Peripheral model returns 8'h3C on cipo while tx_data=8'hFF, p_addr=0 → rx_data=8'h3C; only p_sel_n[0] asserted.
- Start while busy: pulse start_txn with tx_data=8'h00 mid-transfer → ignored; first transaction completes unchanged; exactly one end_txn.
- Clock enable: toggle sys_clk_en 50% during a transfer → timing stretches to 144 sys_clk cycles; data identical.
- Edge cases, three sub-checks:
  - p_addr=3'd5 with P_ADDR_WIDTH=3, PERI_CNT=4 → no select, no busy.
  - Reset asserted at bit 4 → immediate idle outputs, no end_txn.
  - start_txn held high across end_txn → second transaction starts immediately.

Source files
------------

// File: rtl/alpharetz_spi_pkg.sv
// Shared constants and state encoding for the Alpharetz SPI controller.
// The controller and its clock divider both import this package.
package alpharetz_spi_pkg;

  localparam int SPI_DATA_WIDTH_DEF = 8;
  localparam int PERI_CNT_DEF       = 4;
  localparam int P_ADDR_WIDTH_DEF   = 2;
  localparam int CLK_DIV_DEF        = 4;
  localparam int DIV_CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD
  } spi_state_e;

endpackage

// File: rtl/alpharetz_spi_clk_div.sv
// Enable-gated half-period divider for the SPI serial clock.
// Emits a one-cycle tick every CLK_DIV enabled cycles; clear parks it at zero.
module alpharetz_spi_clk_div
  import alpharetz_spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic sys_clk_en,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_CNT_WIDTH-1:0] TERMINAL = DIV_CNT_WIDTH'(CLK_DIV - 1);

  logic [DIV_CNT_WIDTH-1:0] cnt;

  // Combinational so the FSM acts on the same edge the count wraps.
  assign tick = sys_clk_en && !clear && (cnt == TERMINAL);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (sys_clk_en) begin
      if (clear || cnt == TERMINAL) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/alpharetz_spi_controller.sv
// Mode-0 SPI master: one full-duplex word per request, MSB first,
// one active-low select per peripheral, all outputs registered.
module alpharetz_spi_controller
  import alpharetz_spi_pkg::*;
#(
  parameter int SPI_DATA_WIDTH = SPI_DATA_WIDTH_DEF,
  parameter int PERI_CNT       = PERI_CNT_DEF,
  parameter int P_ADDR_WIDTH   = P_ADDR_WIDTH_DEF,
  parameter int CLK_DIV        = CLK_DIV_DEF
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      sys_clk_en,
  input  logic                      start_txn,
  input  logic [SPI_DATA_WIDTH-1:0] tx_data,
  input  logic [P_ADDR_WIDTH-1:0]   p_addr,
  input  logic                      cipo,
  output logic                      copi,
  output logic                      p_clk,
  output logic [PERI_CNT-1:0]       p_sel_n,
  output logic                      end_txn,
  output logic [SPI_DATA_WIDTH-1:0] rx_data,
  output logic                      busy
);

  localparam int BIT_CNT_WIDTH = $clog2(SPI_DATA_WIDTH);
  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(SPI_DATA_WIDTH - 1);

  spi_state_e                state;
  logic [SPI_DATA_WIDTH-1:0] tx_shift;
  logic [SPI_DATA_WIDTH-1:0] rx_shift;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic                      tick;
  logic                      div_clear;
  logic                      addr_ok;

  // Divider restarts from zero on every accepted request.
  assign div_clear = (state == IDLE);
  assign addr_ok   = (32'(p_addr) < 32'(PERI_CNT));

  alpharetz_spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sys_clk_en (sys_clk_en),
    .clear      (div_clear),
    .tick       (tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      copi     <= 1'b0;
      p_clk    <= 1'b0;
      p_sel_n  <= '1;
      end_txn  <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
    end else if (sys_clk_en) begin
      // The completion pulse lives for exactly one enabled cycle.
      end_txn <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_txn && addr_ok) begin
            // tx_shift keeps only the bits still to be sent after the MSB.
            tx_shift <= {tx_data[SPI_DATA_WIDTH-2:0], 1'b0};
            rx_shift <= '0;
            bit_cnt  <= '0;
            copi     <= tx_data[SPI_DATA_WIDTH-1];
            p_sel_n  <= ~(PERI_CNT'(1) << p_addr);
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            state <= TRANSFER;
          end
        end
        TRANSFER: begin
          if (tick) begin
            if (!p_clk) begin
              p_clk    <= 1'b1;
              rx_shift <= {rx_shift[SPI_DATA_WIDTH-2:0], cipo};
            end else begin
              p_clk    <= 1'b0;
              copi     <= tx_shift[SPI_DATA_WIDTH-1];
              tx_shift <= {tx_shift[SPI_DATA_WIDTH-2:0], 1'b0};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + BIT_CNT_WIDTH'(1);
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            p_sel_n <= '1;
            copi    <= 1'b0;
            rx_data <= rx_shift;
            end_txn <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alpharetz_spi_controller.sv
// Self-checking bench for alpharetz_spi_controller: a cycle-level reference
// model derived from the transfer timeline, plus directed scenario checks.
module tb_alpharetz_spi_controller;

  localparam int W     = 8;
  localparam int PERI  = 4;
  localparam int AW    = 3;
  localparam int DIV   = 4;
  localparam int TOTAL = (2 * W + 2) * DIV;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          sys_clk_en;
  logic          start_txn;
  logic [W-1:0]  tx_data;
  logic [AW-1:0] p_addr;
  logic          cipo;
  logic          copi;
  logic          p_clk;
  logic [PERI-1:0] p_sel_n;
  logic          end_txn;
  logic [W-1:0]  rx_data;
  logic          busy;

  int n_checks = 0;
  int n_fails  = 0;

  alpharetz_spi_controller #(
    .SPI_DATA_WIDTH (W),
    .PERI_CNT       (PERI),
    .P_ADDR_WIDTH   (AW),
    .CLK_DIV        (DIV)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sys_clk_en (sys_clk_en),
    .start_txn  (start_txn),
    .tx_data    (tx_data),
    .p_addr     (p_addr),
    .cipo       (cipo),
    .copi       (copi),
    .p_clk      (p_clk),
    .p_sel_n    (p_sel_n),
    .end_txn    (end_txn),
    .rx_data    (rx_data),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Peripheral: either loops copi back, or shifts out periph_word MSB first,
  // advancing one bit after each falling p_clk while selected.
  bit       loopback = 1'b1;
  logic [W-1:0] periph_word = '0;
  int       pbit = 0;
  logic     pclk_prev = 1'b0;
  logic     periph_bit = 1'b0;

  always @(negedge sys_clk) begin
    if (&p_sel_n) pbit = 0;
    else if (pclk_prev && !p_clk) pbit = pbit + 1;
    pclk_prev  = p_clk;
    periph_bit = (pbit < W) ? periph_word[3'(W - 1 - pbit)] : 1'b0;
  end

  assign cipo = loopback ? copi : periph_bit;

  // Reference model: a transaction is a fixed timeline of TOTAL enabled edges
  // counted from the accepting edge.
  bit           m_active  = 1'b0;
  bit           m_end     = 1'b0;
  int           m_k       = 0;
  logic [W-1:0] m_tx      = '0;
  logic [W-1:0] m_rx_exp  = '0;
  logic [W-1:0] m_rx_data = '0;
  logic [AW-1:0] m_addr   = '0;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_active  = 1'b0;
      m_end     = 1'b0;
      m_k       = 0;
      m_rx_data = '0;
    end else if (sys_clk_en) begin
      m_end = 1'b0;
      if (m_active) begin
        m_k = m_k + 1;
        if (m_k == TOTAL) begin
          m_active  = 1'b0;
          m_end     = 1'b1;
          m_rx_data = m_rx_exp;
        end
      end else if (start_txn && int'(p_addr) < PERI) begin
        m_active = 1'b1;
        m_k      = 0;
        m_tx     = tx_data;
        m_addr   = p_addr;
        m_rx_exp = loopback ? tx_data : periph_word;
      end
    end
  end

  // Half-period h: 0 = setup, 1 = leading low, even 2..16 = p_clk high,
  // odd 3..15 = low between pulses, 17 = hold.
  int             c_h;
  int             c_idx;
  logic [PERI-1:0] c_sel;
  logic           c_pclk;

  always @(negedge sys_clk) begin
    check("busy", 32'(busy), 32'(m_active));
    check("end_txn", 32'(end_txn), 32'(m_end));
    check("rx_data", 32'(rx_data), 32'(m_rx_data));
    if (m_active) begin
      c_h    = m_k / DIV;
      c_sel  = ~(PERI'(1) << m_addr);
      c_pclk = (c_h >= 2 && c_h <= 16 && (c_h % 2) == 0);
      check("p_sel_n", 32'(p_sel_n), 32'(c_sel));
      check("p_clk", 32'(p_clk), 32'(c_pclk));
      if (c_h <= 16) begin
        c_idx = (c_h <= 1) ? 0 : (c_h - 1) / 2;
        check("copi", 32'(copi), 32'(m_tx[3'(W - 1 - c_idx)]));
      end
    end else begin
      check("p_sel_n_idle", 32'(p_sel_n), 32'hF);
      check("p_clk_idle", 32'(p_clk), 32'h0);
      check("copi_idle", 32'(copi), 32'h0);
    end
  end

  // Runs one request and gathers what a logic analyser would see on the pins.
  task automatic run_txn(input logic [W-1:0] tx, input logic [AW-1:0] addr,
                         input bit toggle_en, input int poke_at,
                         output int busy_n, output int rises, output logic [W-1:0] bits,
                         output int hi_min, output int hi_max, output int ends,
                         output logic [PERI-1:0] sel_seen);
    int hi_len;
    int idle_after;
    bit prev_clk;
    bit prev_end;
    @(negedge sys_clk);
    tx_data = tx; p_addr = addr; start_txn = 1'b1; sys_clk_en = 1'b1;
    busy_n = 0; rises = 0; bits = '0; hi_min = 1000; hi_max = 0; ends = 0;
    sel_seen = '1; hi_len = 0; idle_after = 0; prev_clk = 1'b0; prev_end = 1'b0;
    for (int cyc = 0; cyc < 400 && idle_after < 6; cyc++) begin
      @(negedge sys_clk);
      start_txn = (cyc == poke_at);
      if (cyc == poke_at) begin
        tx_data = 8'h00;
        p_addr  = 3'd1;
      end
      if (busy) begin
        busy_n++;
        sel_seen = sel_seen & p_sel_n;
      end
      if (p_clk) begin
        if (!prev_clk) begin
          rises++;
          bits = {bits[W-2:0], copi};
        end
        hi_len++;
      end else if (prev_clk) begin
        if (hi_len < hi_min) hi_min = hi_len;
        if (hi_len > hi_max) hi_max = hi_len;
        hi_len = 0;
      end
      if (end_txn && !prev_end) ends++;
      if (ends > 0) idle_after++;
      prev_clk = p_clk;
      prev_end = end_txn;
      sys_clk_en = toggle_en ? ~sys_clk_en : 1'b1;
    end
    sys_clk_en = 1'b1;
  endtask

  task automatic wait_end(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge sys_clk);
      seen = end_txn;
    end
  endtask

  int           busy_n, rises, hi_min, hi_max, ends;
  logic [W-1:0] bits;
  logic [PERI-1:0] sel_seen;
  bit           seen;
  bit           prev;

  initial begin
    sys_rst_n = 1'b0; sys_clk_en = 1'b1; start_txn = 1'b0;
    tx_data = '0; p_addr = '0;
    repeat (3) @(negedge sys_clk);
    check("init_sel", 32'(p_sel_n), 32'hF);
    check("init_busy", 32'(busy), 32'h0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Loopback A5 to peripheral 2.
    loopback = 1'b1;
    run_txn(8'hA5, 3'd2, 1'b0, -1, busy_n, rises, bits, hi_min, hi_max, ends, sel_seen);
    check("lb_busy_cycles", 32'(busy_n), 32'd72);
    check("lb_pclk_pulses", 32'(rises), 32'd8);
    check("lb_copi_bits", 32'(bits), 32'hA5);
    check("lb_high_min", 32'(hi_min), 32'd4);
    check("lb_high_max", 32'(hi_max), 32'd4);
    check("lb_end_pulses", 32'(ends), 32'd1);
    check("lb_sel", 32'(sel_seen), 32'hB);
    check("lb_rx", 32'(rx_data), 32'hA5);

    // Asynchronous reset between edges.
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst_sel", 32'(p_sel_n), 32'hF);
    check("rst_pclk", 32'(p_clk), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_end", 32'(end_txn), 32'h0);
    check("rst_rx", 32'(rx_data), 32'h0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Peripheral returns 3C while we send FF to peripheral 0.
    loopback = 1'b0; periph_word = 8'h3C;
    run_txn(8'hFF, 3'd0, 1'b0, -1, busy_n, rises, bits, hi_min, hi_max, ends, sel_seen);
    check("pm_rx", 32'(rx_data), 32'h3C);
    check("pm_sel", 32'(sel_seen), 32'hE);
    check("pm_copi_bits", 32'(bits), 32'hFF);
    loopback = 1'b1;

    // Start pulse with other data mid-transfer is ignored.
    run_txn(8'hA5, 3'd2, 1'b0, 20, busy_n, rises, bits, hi_min, hi_max, ends, sel_seen);
    check("bz_rx", 32'(rx_data), 32'hA5);
    check("bz_end_pulses", 32'(ends), 32'd1);
    check("bz_busy_cycles", 32'(busy_n), 32'd72);
    check("bz_sel", 32'(sel_seen), 32'hB);

    // 50% clock enable stretches the transfer.
    run_txn(8'hA5, 3'd2, 1'b1, -1, busy_n, rises, bits, hi_min, hi_max, ends, sel_seen);
    check("ce_busy_cycles", 32'(busy_n), 32'd144);
    check("ce_high", 32'(hi_max), 32'd8);
    check("ce_copi_bits", 32'(bits), 32'hA5);
    check("ce_rx", 32'(rx_data), 32'hA5);

    // Out-of-range peripheral index.
    @(negedge sys_clk);
    tx_data = 8'hFF; p_addr = 3'd5; start_txn = 1'b1;
    repeat (4) begin
      @(negedge sys_clk);
      check("oor_busy", 32'(busy), 32'h0);
      check("oor_sel", 32'(p_sel_n), 32'hF);
    end
    start_txn = 1'b0;

    // Reset during bit 4 aborts without a completion pulse.
    @(negedge sys_clk);
    tx_data = 8'h96; p_addr = 3'd3; start_txn = 1'b1;
    @(negedge sys_clk);
    start_txn = 1'b0;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 300 && rises < 4; i++) begin
      @(negedge sys_clk);
      if (p_clk && !prev) rises++;
      prev = p_clk;
    end
    check("ab_reached_bit4", 32'(rises), 32'd4);
    check("ab_busy_before", 32'(busy), 32'h1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("ab_sel", 32'(p_sel_n), 32'hF);
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_pclk", 32'(p_clk), 32'h0);
    check("ab_rx", 32'(rx_data), 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    ends = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (end_txn) ends++;
    end
    check("ab_no_end", 32'(ends), 32'd0);

    // start_txn held through completion restarts immediately.
    @(negedge sys_clk);
    tx_data = 8'hC3; p_addr = 3'd1; start_txn = 1'b1;
    wait_end(300, seen);
    check("b2b_first_end", 32'(seen), 32'h1);
    check("b2b_first_rx", 32'(rx_data), 32'hC3);
    check("b2b_idle_at_end", 32'(busy), 32'h0);
    tx_data = 8'h5A;
    @(negedge sys_clk);
    check("b2b_restart", 32'(busy), 32'h1);
    start_txn = 1'b0;
    wait_end(300, seen);
    check("b2b_second_end", 32'(seen), 32'h1);
    check("b2b_second_rx", 32'(rx_data), 32'h5A);
    repeat (4) @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
